// File: rtl/btn_event_decoder.sv
// Classifies a debounced push-button level into short press, long press and
// double click pulses, plus a held level for an ongoing long press.
module btn_event_decoder #(
  parameter int LONG_CYCLES = 1000,
  parameter int DBL_GAP     = 250,
  parameter int CW          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    DOWN1,
    WAIT2,
    DOWN2,
    LONG
  } state_t;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DBL_GAP - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // One counter serves both the hold timer (DOWN1) and the gap timer (WAIT2);
  // a release beats a long-press timeout and a re-press beats a gap timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARM;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      held         <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      case (state)
        ARM: begin
          if (!level) state <= IDLE;
        end
        IDLE: begin
          if (level) begin
            state <= DOWN1;
            cnt   <= '0;
          end
        end
        DOWN1: begin
          if (!level) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG;
            long_press <= 1'b1;
            held       <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT2: begin
          if (level) begin
            state        <= DOWN2;
            double_click <= 1'b1;
          end else if (cnt == GAP_LAST) begin
            state       <= IDLE;
            short_press <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DOWN2: begin
          if (!level) state <= IDLE;
        end
        LONG: begin
          if (!level) begin
            state <= IDLE;
            held  <= 1'b0;
          end
        end
        default: begin
          state <= ARM;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
